// File: rtl/add_hold_pkg.sv
// ============================================================================
// add_hold_pkg : shared types and defaults for the adder hold register bank
// Revision     : 1.0
// ============================================================================
`default_nettype none

package add_hold_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2,
    STALE = 2'd3
  } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/add_hold_drv.sv
// ============================================================================
// add_hold_drv : one tri-state bus driver with split MSB / low-bit enables
// Revision     : 1.0
// ============================================================================
`default_nettype none

module add_hold_drv
  import add_hold_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             hi_en_i,
  input  logic             lo_en_i,
  input  logic             valid_i,
  output wire  [WIDTH-1:0] bus_o
);

  logic w_hi_drv;
  logic w_lo_drv;

  // An EMPTY register never drives, whatever the enables say.
  assign w_hi_drv = hi_en_i & valid_i;
  assign w_lo_drv = lo_en_i & valid_i;

  assign bus_o[WIDTH-1]   = w_hi_drv ? data_i[WIDTH-1] : 1'bz;
  assign bus_o[WIDTH-2:0] = w_lo_drv ? data_i[WIDTH-2:0] : {(WIDTH-1){1'bz}};

endmodule

`default_nettype wire

// File: rtl/add_hold_bank.sv
// ============================================================================
// add_hold_bank : ALU result hold register with age tracking, driving NBUS
//                 shared tri-state buses; state updates on falling phi_2.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module add_hold_bank
  import add_hold_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NBUS      = 2,
  parameter int AGE_W     = 3,
  parameter int STALE_AGE = 4
) (
  input  logic                  phi_2,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  load,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      alu_in,
  input  logic                  alu_carry,
  input  logic                  alu_ovf,
  input  logic [NBUS-1:0]       drv_hi_en,
  input  logic [NBUS-1:0]       drv_lo_en,
  output wire  [NBUS*WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0]      hold_q,
  output logic                  carry_q,
  output logic                  ovf_q,
  output logic [1:0]            state_q,
  output logic [AGE_W-1:0]      age_q,
  output logic                  stale,
  input  logic                  clr_err,
  output logic                  err_empty_drv
);

  localparam logic [AGE_W-1:0] STALE_AGE_C = AGE_W'(STALE_AGE);
  localparam logic [AGE_W-1:0] STALE_M1_C  = AGE_W'(STALE_AGE - 1);
  localparam logic [AGE_W-1:0] AGE_ONE_C   = AGE_W'(1);

  logic [WIDTH-1:0] data_q,  data_d;
  logic             cy_q,    cy_d;
  logic             ov_q,    ov_d;
  hold_state_t      st_q,    st_d;
  logic [AGE_W-1:0] age_r_q, age_r_d;
  logic             err_q,   err_d;

  logic             w_valid;
  logic             w_any_en;

  // State register
  always_ff @(negedge phi_2 or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      st_q    <= EMPTY;
      age_r_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      st_q    <= st_d;
      age_r_q <= age_r_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    data_d  = data_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    st_d    = st_q;
    age_r_d = age_r_q;
    if (rdy) begin
      if (flush) begin
        st_d    = EMPTY;
        age_r_d = '0;
      end else if (load) begin
        data_d  = alu_in;
        cy_d    = alu_carry;
        ov_d    = alu_ovf;
        st_d    = FRESH;
        age_r_d = '0;
      end else begin
        case (st_q)
          FRESH: begin
            st_d    = HELD;
            age_r_d = AGE_ONE_C;
          end
          HELD: begin
            // Saturating compare keeps STALE_AGE == 1 from wrapping the counter.
            if (age_r_q >= STALE_M1_C) begin
              st_d    = STALE;
              age_r_d = STALE_AGE_C;
            end else begin
              age_r_d = age_r_q + 1'b1;
            end
          end
          STALE:   age_r_d = STALE_AGE_C;
          default: ;
        endcase
      end
    end
  end

  // The error is sampled on every edge, stalled or not, from the pre-edge state.
  assign w_any_en = |{drv_hi_en, drv_lo_en};

  always_comb begin
    err_d = err_q & ~clr_err;
    if ((st_q == EMPTY) && w_any_en) begin
      err_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    w_valid       = (st_q != EMPTY);
    stale         = (st_q == STALE);
    hold_q        = data_q;
    carry_q       = cy_q;
    ovf_q         = ov_q;
    state_q       = st_q;
    age_q         = age_r_q;
    err_empty_drv = err_q;
  end

  generate
    for (genvar k = 0; k < NBUS; k++) begin : g_bus
      add_hold_drv #(
        .WIDTH (WIDTH)
      ) u_drv (
        .data_i  (data_q),
        .hi_en_i (drv_hi_en[k]),
        .lo_en_i (drv_lo_en[k]),
        .valid_i (w_valid),
        .bus_o   (bus_out[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_add_hold_bank.sv
// ============================================================================
// tb_add_hold_bank : scoreboard bench for add_hold_bank (WIDTH=8, NBUS=2)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_add_hold_bank;

  typedef logic [48:0] obs_t;

  logic        phi_2 = 1'b1;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        load = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  alu_in = 8'h00;
  logic        alu_carry = 1'b0;
  logic        alu_ovf = 1'b0;
  logic [1:0]  drv_hi_en = 2'b00;
  logic [1:0]  drv_lo_en = 2'b00;
  logic        clr_err = 1'b0;

  wire  [15:0] bus_out;
  wire  [7:0]  hold_q;
  wire         carry_q;
  wire         ovf_q;
  wire  [1:0]  state_q;
  wire  [2:0]  age_q;
  wire         stale;
  wire         err_empty_drv;

  wire  [15:0] w_busz;
  wire  [15:0] w_dat;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t exp_v;
  obs_t obs_v;

  add_hold_bank u_dut (
    .phi_2         (phi_2),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .load          (load),
    .flush         (flush),
    .alu_in        (alu_in),
    .alu_carry     (alu_carry),
    .alu_ovf       (alu_ovf),
    .drv_hi_en     (drv_hi_en),
    .drv_lo_en     (drv_lo_en),
    .bus_out       (bus_out),
    .hold_q        (hold_q),
    .carry_q       (carry_q),
    .ovf_q         (ovf_q),
    .state_q       (state_q),
    .age_q         (age_q),
    .stale         (stale),
    .clr_err       (clr_err),
    .err_empty_drv (err_empty_drv)
  );

  always #5 phi_2 = ~phi_2;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_zdet
      assign w_busz[gi] = (bus_out[gi] === 1'bz);
      assign w_dat[gi]  = w_busz[gi] ? 1'b0 : bus_out[gi];
    end
  endgenerate

  // Expected snapshot from spec rules; bus drive follows the enables present now.
  function automatic obs_t mk(input logic [7:0] h, input logic c, input logic o,
                              input logic [1:0] st, input logic [2:0] age, input logic err);
    logic [15:0] en;
    logic [15:0] dat;
    en  = '0;
    dat = '0;
    for (int k = 0; k < 2; k++) begin
      if (st != 2'd0 && drv_hi_en[k]) begin
        en[k*8+7]  = 1'b1;
        dat[k*8+7] = h[7];
      end
      if (st != 2'd0 && drv_lo_en[k]) begin
        en[k*8 +: 7]  = 7'h7F;
        dat[k*8 +: 7] = h[6:0];
      end
    end
    return {h, c, o, st, age, (st == 2'd3), err, en, dat};
  endfunction

  function automatic obs_t observe();
    return {hold_q, carry_q, ovf_q, state_q, age_q, stale, err_empty_drv, ~w_busz, w_dat};
  endfunction

  task automatic tick();
    @(negedge phi_2);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0));
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_values: got %h exp %h", obs_v, exp_v); end

    @(posedge phi_2);
    rst_n     = 1'b1;
    drv_hi_en = 2'b11;
    drv_lo_en = 2'b11;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0));
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL empty_bus_z: got %h exp %h", obs_v, exp_v); end

    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1));
    tick();
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL err_set: got %h exp %h", obs_v, exp_v); end

    drv_hi_en = 2'b00;
    drv_lo_en = 2'b00;
    clr_err   = 1'b1;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0));
    tick();
    clr_err = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL err_clear: got %h exp %h", obs_v, exp_v); end
  endtask

  task automatic test_load();
    alu_in = 8'hA5; alu_carry = 1'b1; alu_ovf = 1'b0; load = 1'b1;
    sb.push_back(mk(8'hA5, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0));
    tick();
    load = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL load_capture: got %h exp %h", obs_v, exp_v); end

    drv_lo_en = 2'b01;
    drv_hi_en = 2'b10;
    #1;
    sb.push_back(mk(8'hA5, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0));
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL bus_split: got %h exp %h", obs_v, exp_v); end

    checks++;
    if ({~w_busz, w_dat} !== {16'h807F, 16'h8025}) begin
      errors++;
      $display("FAIL bus_split_literal: got en=%h dat=%h exp en=807f dat=8025", ~w_busz, w_dat);
    end
  endtask

  task automatic test_aging();
    logic [1:0] st_tab  [7];
    logic [2:0] age_tab [7];
    st_tab  = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    age_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(mk(8'hA5, 1'b1, 1'b0, st_tab[i], age_tab[i], 1'b0));
      tick();
      exp_v = sb.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL aging[%0d]: got %h exp %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_stall();
    alu_in = 8'h5A; alu_carry = 1'b0; alu_ovf = 1'b1; load = 1'b1;
    sb.push_back(mk(8'h5A, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0));
    tick();
    load = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL stall_preload: got %h exp %h", obs_v, exp_v); end

    for (int i = 1; i <= 2; i++) begin
      sb.push_back(mk(8'h5A, 1'b0, 1'b1, 2'd2, 3'(i), 1'b0));
      tick();
      exp_v = sb.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL stall_age[%0d]: got %h exp %h", i, obs_v, exp_v); end
    end

    rdy = 1'b0; load = 1'b1; alu_in = 8'h3C; alu_carry = 1'b1; alu_ovf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 4);
      sb.push_back(mk(8'h5A, 1'b0, 1'b1, 2'd2, 3'd2, 1'b0));
      tick();
      exp_v = sb.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, obs_v, exp_v); end
    end

    rdy = 1'b1; flush = 1'b0;
    sb.push_back(mk(8'h3C, 1'b1, 1'b1, 2'd1, 3'd0, 1'b0));
    tick();
    load = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL stall_release: got %h exp %h", obs_v, exp_v); end
  endtask

  task automatic test_flush_priority();
    load = 1'b1; flush = 1'b1; alu_in = 8'h77; alu_carry = 1'b0; alu_ovf = 1'b0;
    sb.push_back(mk(8'h3C, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0));
    tick();
    load = 1'b0; flush = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL flush_over_load: got %h exp %h", obs_v, exp_v); end
    drv_hi_en = 2'b00;
    drv_lo_en = 2'b00;
  endtask

  task automatic test_back_to_back();
    drv_hi_en = 2'b01; clr_err = 1'b1;
    sb.push_back(mk(8'h3C, 1'b1, 1'b1, 2'd0, 3'd0, 1'b1));
    tick();
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL err_set_wins: got %h exp %h", obs_v, exp_v); end

    drv_hi_en = 2'b00;
    sb.push_back(mk(8'h3C, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0));
    tick();
    clr_err = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL err_clr_again: got %h exp %h", obs_v, exp_v); end

    load = 1'b1; alu_in = 8'h11; alu_carry = 1'b0; alu_ovf = 1'b0;
    sb.push_back(mk(8'h11, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0));
    tick();
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_first: got %h exp %h", obs_v, exp_v); end

    alu_in = 8'h22; alu_carry = 1'b1;
    sb.push_back(mk(8'h22, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0));
    tick();
    load = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_second: got %h exp %h", obs_v, exp_v); end

    sb.push_back(mk(8'h22, 1'b1, 1'b0, 2'd2, 3'd1, 1'b0));
    tick();
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_aged: got %h exp %h", obs_v, exp_v); end
  endtask

  task automatic test_async_reset();
    load = 1'b1; alu_in = 8'hFF; alu_carry = 1'b0; alu_ovf = 1'b0;
    sb.push_back(mk(8'hFF, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0));
    tick();
    load = 1'b0;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL ff_load: got %h exp %h", obs_v, exp_v); end

    drv_hi_en = 2'b01; drv_lo_en = 2'b01;
    #1;
    sb.push_back(mk(8'hFF, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0));
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL bus0_ff: got %h exp %h", obs_v, exp_v); end

    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0));
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL async_reset: got %h exp %h", obs_v, exp_v); end

    checks++;
    if (w_busz !== 16'hFFFF) begin errors++; $display("FAIL async_reset_busz: got zmask=%h exp ffff", w_busz); end

    drv_hi_en = 2'b00; drv_lo_en = 2'b00;
    #1;
    rst_n = 1'b1;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0));
    tick();
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL post_reset_edge: got %h exp %h", obs_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_aging();
    test_stall();
    test_flush_priority();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, exp completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/add_hold_bank.md
# add_hold_bank

Parametrised adder hold register for the datapath. It captures the ALU result together with its carry and overflow flags on the falling edge of phi_2. It drives the held value onto any of NBUS shared tri-state buses, with the MSB and low bits enabled separately, as the SB bus split requires. It also tracks whether the held value is empty, fresh, held or stale, honours RDY stalls, and flags any attempt to drive a bus from an empty register.

## Interface
Parameters:
- WIDTH, 8: data width; must be ≥ 2.
- NBUS, 2: number of tri-state output buses (bus 0 = ADL, bus 1 = SB by convention).
- AGE_W, 3: width of the age counter.
- STALE_AGE, 4: age at which the value becomes stale; must be 1..2^AGE_W−1.

Ports (all sequential logic uses one clock, phi_2; reset is asynchronous and active-low):
- phi_2  in  1  clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  1 = advance; 0 = stall, all state frozen except err_empty_drv.
- load  in  1  capture alu_in/alu_carry/alu_ovf at this edge.
- flush  in  1  invalidate the held value.
- alu_in  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry out.
- alu_ovf  in  1  ALU overflow out.
- drv_hi_en  in  NBUS  per-bus enable for bit WIDTH−1.
- drv_lo_en  in  NBUS  per-bus enable for bits WIDTH−2:0.
- bus_out  out  NBUS*WIDTH  tri-state; bus k occupies bits [k*WIDTH +: WIDTH].
- hold_q  out  WIDTH  non-tristate copy of the held value.
- carry_q, ovf_q  out  1 each  held flags.
- state_q  out  2  EMPTY=0, FRESH=1, HELD=2, STALE=3.
- age_q  out  AGE_W  edges since the last load, saturating.
- stale  out  1  state_q == STALE.
- clr_err  in  1  clear err_empty_drv.
- err_empty_drv  out  1  sticky error: a bus was enabled while the register was EMPTY.

## Operation
- Reset values: hold_q=0, carry_q=0, ovf_q=0, state_q=EMPTY, age_q=0, err_empty_drv=0, all bus_out=z.
- Bus drive is combinational from the enables, state and hold_q:
  - bus k bit WIDTH−1 = hold_q[WIDTH−1] when drv_hi_en[k] && state_q != EMPTY, else z.
  - bus k bits WIDTH−2:0 = hold_q[WIDTH−2:0] when drv_lo_en[k] && state_q != EMPTY, else z.
  - Buses are independent; any number may be driven at the same time.
- On each falling edge with rdy=1, the first matching rule applies:
  - flush: state EMPTY, age 0; data and flags keep their value.
  - load: capture data and both flags; state FRESH, age 0.
  - FRESH: state HELD, age 1.
  - HELD: age+1; state becomes STALE when the new age == STALE_AGE.
  - STALE: no change; age saturates at STALE_AGE.
  - EMPTY: no change.
- flush has priority over load.
- With rdy=0, data, flags, state and age all hold, including when load or flush is asserted.
- err_empty_drv updates on every falling edge, independent of rdy:
  - set when state_q == EMPTY and any drv_hi_en or drv_lo_en bit is 1;
  - otherwise cleared by clr_err;
  - set wins over clr_err on the same edge.
- STALE values still drive normally; stale is informational only.

## Timing
- Load-to-output latency: hold_q, the flags and the bus data change right after the capturing falling edge, and are valid for the whole following phi_2 high phase.
- Enable-to-bus: combinational, with no register in the path.
- Reset is asynchronous: asserting rst_n mid-operation releases all buses to z immediately, because state becomes EMPTY.
- The first falling edge after rst_n deasserts is a normal edge.
- A load during the EMPTY→FRESH edge with the enables already high does not set err_empty_drv, because the error is sampled from the pre-edge state.
- There is no combinational path from alu_in to bus_out.

## Structure
- Package add_hold_pkg holds:
  - the hold_state_t enum (EMPTY, FRESH, HELD, STALE, 2 bits);
  - the default WIDTH localparam.
- Sub-module add_hold_drv is one bus driver (hi/lo enable split, EMPTY gating); it is instantiated NBUS times in a generate loop.
- State, age and error logic live in the top module.

## Test plan
- Reset, then enable all buses → bus_out all z; err_empty_drv=1 after the next edge; clr_err alone on the following edge (enables low) → 0.
- load alu_in=8'hA5, carry=1, ovf=0; drive drv_lo_en[0]=1 and drv_hi_en[1]=1 only → bus0 = z,0100101b; bus1 = 1,zzzzzzz; carry_q=1; state FRESH.
- After the load, 4 idle edges (STALE_AGE=4) → state FRESH, HELD(1), HELD(2), HELD(3), STALE(4); a further 3 edges → age stays 4 and stale=1.
- rdy=0 for 5 edges with load=1 and alu_in=8'h3C while HELD, age 2 → hold_q, state and age unchanged; rdy=1 → captures 8'h3C, state FRESH.
- Assert load and flush on the same edge with value 8'h77 → state EMPTY, hold_q keeps its prior value, buses z.
- Pulse rst_n low between edges while bus0 is driving 8'hFF → bus0 goes to z immediately; all outputs at their reset values.
